// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480 VGA timing constants and receiver FSM encoding
package vga_timing_pkg;

    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_e;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - rising/falling edge detector against one registered copy of the input
module sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA sync receiver: pixel/line counters, timing lock FSM, error pulses
// Optional error counter output err_cnt enabled by macro VGA_SYNC_RX_ERRCNT_EN.
module vga_sync_rx #(
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       blank,
    output logic       de,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       locked,
    output logic       frame_start,
    output logic       h_err,
    output logic       v_err
`ifdef VGA_SYNC_RX_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    import vga_timing_pkg::rx_state_e;
    import vga_timing_pkg::SEARCH;
    import vga_timing_pkg::MEASURE;
    import vga_timing_pkg::LOCKED;
    import vga_timing_pkg::sat_inc10;

    localparam logic [9:0]  H_TOTAL_C  = 10'(H_TOTAL);
    localparam logic [9:0]  V_TOTAL_C  = 10'(V_TOTAL);
    localparam logic [10:0] H_ACTIVE_C = 11'(H_ACTIVE);
    localparam logic [7:0]  LOCK_C     = 8'(LOCK_FRAMES);

    logic hs_rise, hs_fall, vs_rise, vs_fall, bl_rise, bl_fall;
    logic unused_edges;

    sync_edge u_hs (.clk_i(pclk), .rst_i(rst), .sig_i(hsync), .rise_o(hs_rise), .fall_o(hs_fall));
    sync_edge u_vs (.clk_i(pclk), .rst_i(rst), .sig_i(vsync), .rise_o(vs_rise), .fall_o(vs_fall));
    sync_edge u_bl (.clk_i(pclk), .rst_i(rst), .sig_i(blank), .rise_o(bl_rise), .fall_o(bl_fall));

    assign unused_edges = hs_fall ^ vs_fall;

    rx_state_e   state_q, state_d;
    logic [7:0]  good_q, good_d;
    logic        skip_q, skip_d;
    logic [9:0]  hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        de_q, de_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        h_err_q, h_err_d;
    logic        v_err_q, v_err_d;
    logic        fs_q;
    logic        fsm_h_err;
    logic        run_end, run_err;
    logic [10:0] run_len;

    // hcnt is loaded with 1 in the edge cycle, so at the next edge it holds the full line period
    always_comb begin
        hcnt_d = hs_rise ? 10'd1 : sat_inc10(hcnt_q);
        vcnt_d = vcnt_q;
        if (vs_rise) begin
            vcnt_d = 10'd0;
        end else if (hs_rise) begin
            vcnt_d = sat_inc10(vcnt_q);
        end

        de_d = ~blank;
        x_d  = x_q;
        if (bl_fall) begin
            x_d = 10'd0;
        end else if (de_d && de_q) begin
            x_d = sat_inc10(x_q);
        end

        run_end = bl_rise & de_q;
        run_len = {1'b0, x_q} + 11'd1;
        run_err = run_end && (state_q == LOCKED) && (run_len != H_ACTIVE_C);

        y_d = y_q;
        if (vs_rise) begin
            y_d = 9'd0;
        end else if (run_end && y_q != 9'h1FF) begin
            y_d = y_q + 9'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        skip_d    = skip_q;
        fsm_h_err = 1'b0;
        v_err_d   = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (vs_rise) begin
                    state_d = MEASURE;
                    good_d  = 8'd0;
                    skip_d  = 1'b1;
                end
            end
            MEASURE, LOCKED: begin
                if (hcnt_d == 10'h3FF || (hs_rise && !skip_q && hcnt_q != H_TOTAL_C)) begin
                    fsm_h_err = 1'b1;
                    state_d   = SEARCH;
                end else if (vs_rise && vcnt_q != V_TOTAL_C) begin
                    v_err_d = 1'b1;
                    state_d = SEARCH;
                end else begin
                    if (hs_rise) begin
                        skip_d = 1'b0;
                    end
                    if (vs_rise && state_q == MEASURE) begin
                        good_d = good_q + 8'd1;
                        if (good_d >= LOCK_C) begin
                            state_d = LOCKED;
                        end
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
        h_err_d = fsm_h_err | run_err;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;
            good_q  <= 8'd0;
            skip_q  <= 1'b0;
            hcnt_q  <= 10'd0;
            vcnt_q  <= 10'd0;
            de_q    <= 1'b0;
            x_q     <= 10'd0;
            y_q     <= 9'd0;
            h_err_q <= 1'b0;
            v_err_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            skip_q  <= skip_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            h_err_q <= h_err_d;
            v_err_q <= v_err_d;
            fs_q    <= vs_rise;
        end
    end

    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign locked      = (state_q == LOCKED);
    assign frame_start = fs_q;
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;

`ifdef VGA_SYNC_RX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Simultaneous h_err and v_err count as a single event
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if ((h_err_q | v_err_q) && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - scoreboard bench for vga_sync_rx on a reduced 40x20 raster
module tb_vga_sync_rx;

    localparam int H_TOT = 40;
    localparam int V_TOT = 20;
    localparam int H_ACT = 24;
    localparam int V_ACT = 12;
    localparam int HS_START = 28;
    localparam int HS_W = 4;
    localparam int VS_LINE = 15;
    localparam int EV_FS = 0, EV_HERR = 1, EV_VERR = 2, EV_LUP = 3, EV_LDN = 4;

    logic pclk = 1'b0;
    logic rst = 1'b1;
    logic hsync = 1'b0;
    logic vsync = 1'b0;
    logic blank = 1'b1;
    logic de, locked, frame_start, h_err, v_err;
    logic [9:0] x;
    logic [8:0] y;
`ifdef VGA_SYNC_RX_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    typedef struct {int kind; int cyc;} ev_t;
    typedef struct {int px; int py; int cyc;} px_t;
    ev_t exp_q[$];
    px_t pix_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int last_hs = 0;
    logic locked_prev = 1'b0;

    vga_sync_rx #(.H_TOTAL(H_TOT), .V_TOTAL(V_TOT), .H_ACTIVE(H_ACT), .LOCK_FRAMES(2)) dut (
        .pclk(pclk), .rst(rst), .hsync(hsync), .vsync(vsync), .blank(blank),
        .de(de), .x(x), .y(y), .locked(locked), .frame_start(frame_start),
        .h_err(h_err), .v_err(v_err)
`ifdef VGA_SYNC_RX_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input int kind);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].kind == kind && exp_q[i].cyc == cyc) idx = i;
        checks++;
        assert (idx >= 0) else begin
            errors++;
            $error("FAIL event: observed kind %0d at cycle %0d, expected no such event", kind, cyc);
        end
        if (idx >= 0) exp_q.delete(idx);
    endtask

    always @(negedge pclk) begin
        px_t p;
        if (!rst) begin
            if (frame_start) match_ev(EV_FS);
            if (h_err) match_ev(EV_HERR);
            if (v_err) match_ev(EV_VERR);
            if (locked && !locked_prev) match_ev(EV_LUP);
            if (!locked && locked_prev) match_ev(EV_LDN);
            if (de) begin
                checks++;
                assert (pix_q.size() > 0) else begin
                    errors++;
                    $error("FAIL pixel: observed de=1 at cycle %0d, expected de=0", cyc);
                end
                if (pix_q.size() > 0) begin
                    p = pix_q.pop_front();
                    chk("x", 32'(x), p.px);
                    chk("y", 32'(y), p.py);
                    chk("de_cycle", cyc, p.cyc);
                end
            end
        end
        locked_prev = locked;
    end

    task automatic step(input logic hs, input logic vs, input logic bl);
        hsync = hs;
        vsync = vs;
        blank = bl;
        @(posedge pclk);
        #1;
    endtask

    // vs_ev bits: 0 lock up, 1 v_err (with lock loss) at this frame's vsync edge
    task automatic run_frame(input int n_lines, input int short_line, input int bad_line,
                             input bit bad_all, input int vs_ev, input bit sh_err, input bit run_err);
        px_t p;
        for (int v = 0; v < n_lines; v++) begin
            int len;
            bit bad;
            len = (v == short_line) ? H_TOT - 1 : H_TOT;
            bad = (v == bad_line) || bad_all;
            for (int h = 0; h < len; h++) begin
                bit hs, vs, act;
                hs  = (h >= HS_START) && (h < HS_START + HS_W);
                vs  = (v >= VS_LINE) && (v < VS_LINE + 2);
                act = (v < V_ACT) && (h < (bad ? H_ACT - 1 : H_ACT));
                step(hs, vs, !act);
                if (hs && h == HS_START) begin
                    if (sh_err && v == short_line + 1) begin
                        push_ev(EV_HERR, cyc);
                        push_ev(EV_LDN, cyc);
                    end
                    last_hs = cyc;
                end
                if (vs && v == VS_LINE && h == 0) begin
                    push_ev(EV_FS, cyc);
                    if (vs_ev[0]) push_ev(EV_LUP, cyc);
                    if (vs_ev[1]) begin
                        push_ev(EV_VERR, cyc);
                        push_ev(EV_LDN, cyc);
                    end
                end
                if (act) begin
                    p.px = h;
                    p.py = v;
                    p.cyc = cyc;
                    pix_q.push_back(p);
                end
                if (run_err && bad && v < V_ACT && h == H_ACT - 1) push_ev(EV_HERR, cyc);
            end
        end
    endtask

    task automatic mid_frame_reset();
        run_frame(8, -1, -1, 1'b0, 0, 1'b0, 1'b0);
        chk("pending_pixels_before_rst", pix_q.size(), 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_locked", locked, 0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("rst_de", de, 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        pix_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("reset_locked", locked, 0);
        chk("reset_de", de, 0);
        chk("reset_x", 32'(x), 0);
        chk("reset_y", 32'(y), 0);
        chk("reset_frame_start", frame_start, 0);
        chk("reset_h_err", h_err, 0);
        chk("reset_v_err", v_err, 0);
`ifdef VGA_SYNC_RX_ERRCNT_EN
        chk("reset_err_cnt", 32'(err_cnt), 0);
`endif
        rst = 1'b0;

        run_frame(V_TOT, -1, -1, 1'b0, 0, 1'b0, 1'b0);
        run_frame(V_TOT, -1, -1, 1'b0, 0, 1'b0, 1'b0);
        chk("not_locked_after_1_good", locked, 0);
        run_frame(V_TOT, -1, -1, 1'b0, 1, 1'b0, 1'b0);
        chk("locked_after_2_good", locked, 1);
        run_frame(V_TOT, -1, -1, 1'b0, 0, 1'b0, 1'b0);
        chk("pending_nominal", exp_q.size(), 0);

        run_frame(V_TOT, 5, -1, 1'b0, 0, 1'b1, 1'b0);
        chk("unlocked_short_line", locked, 0);
        run_frame(V_TOT, -1, -1, 1'b0, 0, 1'b0, 1'b0);
        run_frame(V_TOT, -1, -1, 1'b0, 1, 1'b0, 1'b0);
        chk("relock_short_line", locked, 1);
        chk("pending_short_line", exp_q.size(), 0);

        run_frame(V_TOT - 1, -1, -1, 1'b0, 0, 1'b0, 1'b0);
        run_frame(V_TOT, -1, -1, 1'b0, 2, 1'b0, 1'b0);
        chk("unlocked_short_frame", locked, 0);
        run_frame(V_TOT, -1, -1, 1'b0, 0, 1'b0, 1'b0);
        run_frame(V_TOT, -1, -1, 1'b0, 0, 1'b0, 1'b0);
        run_frame(V_TOT, -1, -1, 1'b0, 1, 1'b0, 1'b0);
        chk("relock_short_frame", locked, 1);
        chk("pending_short_frame", exp_q.size(), 0);

        run_frame(V_TOT, -1, 3, 1'b0, 0, 1'b0, 1'b1);
        chk("locked_after_short_run", locked, 1);
        chk("pending_short_run", exp_q.size(), 0);

        push_ev(EV_HERR, last_hs + 1022);
        push_ev(EV_LDN, last_hs + 1022);
        for (int i = 0; i < 1100; i++) step(1'b0, 1'b0, 1'b1);
        chk("unlocked_hsync_stuck", locked, 0);
        chk("pending_hsync_stuck", exp_q.size(), 0);

        run_frame(V_TOT, -1, -1, 1'b0, 0, 1'b0, 1'b0);
        run_frame(V_TOT, -1, -1, 1'b0, 0, 1'b0, 1'b0);
        run_frame(V_TOT, -1, -1, 1'b0, 1, 1'b0, 1'b0);
        chk("relock_hsync_stuck", locked, 1);

        mid_frame_reset();
        run_frame(V_TOT, -1, -1, 1'b0, 0, 1'b0, 1'b0);
        run_frame(V_TOT, -1, -1, 1'b0, 0, 1'b0, 1'b0);
        chk("no_lock_soon_after_rst", locked, 0);
        run_frame(V_TOT, -1, -1, 1'b0, 1, 1'b0, 1'b0);
        chk("relock_after_rst", locked, 1);
        chk("pending_rst", exp_q.size(), 0);

`ifdef VGA_SYNC_RX_ERRCNT_EN
        run_frame(V_TOT, -1, -1, 1'b1, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("err_cnt_12", 32'(err_cnt), 12);
        for (int f = 0; f < 24; f++) run_frame(V_TOT, -1, -1, 1'b1, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("err_cnt_saturated", 32'(err_cnt), 255);
        chk("pending_err_cnt", exp_q.size(), 0);
        mid_frame_reset();
        chk("err_cnt_after_rst", 32'(err_cnt), 0);
        chk("locked_after_rst_errcnt", locked, 0);
`endif

        step(1'b0, 1'b0, 1'b1);
        chk("pending_events_final", exp_q.size(), 0);
        chk("pending_pixels_final", pix_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
